alu_mem_unit: RTL and testbench



---
 rtl/alu_mem_unit.sv | 86 ++++++++
 tb/tb_alu_mem_unit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/alu_mem_unit.sv
// Execute/memory slice: ALU-control decode, 16-bit ALU and an 8-word data memory
// addressed by the ALU result (word index = alu_result[3:1]).
module alu_mem_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  alu_op,
  input  logic [3:0]  opcode,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] mem_write_data,
  input  logic        mem_write_enable,
  input  logic        mem_read_enable,
  output logic [2:0]  alu_cnt,
  output logic [15:0] alu_result,
  output logic        iszero,
  output logic [15:0] mem_read_data
);

  typedef enum logic [2:0] {
    FN_ADD = 3'b000,
    FN_SUB = 3'b001,
    FN_INV = 3'b010,
    FN_SLL = 3'b011,
    FN_SRL = 3'b100,
    FN_AND = 3'b101,
    FN_OR  = 3'b110,
    FN_SLT = 3'b111
  } alu_fn_t;

  alu_fn_t     fn;
  logic [15:0] mem [8];
  logic [2:0]  word_idx;

  always_comb begin
    fn = FN_ADD;
    unique case (alu_op)
      2'b01: fn = FN_SUB;
      2'b00: begin
        unique case (opcode)
          4'b0010: fn = FN_ADD;
          4'b0011: fn = FN_SUB;
          4'b0100: fn = FN_INV;
          4'b0101: fn = FN_SLL;
          4'b0110: fn = FN_SRL;
          4'b0111: fn = FN_AND;
          4'b1000: fn = FN_OR;
          4'b1001: fn = FN_SLT;
          default: fn = FN_ADD;
        endcase
      end
      default: fn = FN_ADD;
    endcase
  end

  assign alu_cnt = fn;

  // Shifts use the full 16-bit b, so amounts of 16 or more naturally produce 0.
  always_comb begin
    alu_result = '0;
    unique case (fn)
      FN_ADD: alu_result = a + b;
      FN_SUB: alu_result = a - b;
      FN_INV: alu_result = ~a;
      FN_SLL: alu_result = a << b;
      FN_SRL: alu_result = a >> b;
      FN_AND: alu_result = a & b;
      FN_OR:  alu_result = a | b;
      FN_SLT: alu_result = (a < b) ? 16'd1 : 16'd0;
      default: alu_result = '0;
    endcase
  end

  assign iszero   = (alu_result == 16'h0000);
  assign word_idx = alu_result[3:1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem <= '{default: '0};
    end else if (mem_write_enable) begin
      mem[word_idx] <= mem_write_data;
    end
  end

  assign mem_read_data = mem_read_enable ? mem[word_idx] : '0;

endmodule

// File: tb/tb_alu_mem_unit.sv
// Self-checking bench for alu_mem_unit: directed cases plus randomized traffic
// compared against a behavioural model of decode, arithmetic and memory.
`timescale 1ns/1ps
module tb_alu_mem_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  alu_op;
  logic [3:0]  opcode;
  logic [15:0] a, b;
  logic [15:0] mem_write_data;
  logic        mem_write_enable;
  logic        mem_read_enable;
  logic [2:0]  alu_cnt;
  logic [15:0] alu_result;
  logic        iszero;
  logic [15:0] mem_read_data;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [15:0] mem_m [8];

  alu_mem_unit dut (
    .clk(clk), .reset(reset), .alu_op(alu_op), .opcode(opcode), .a(a), .b(b),
    .mem_write_data(mem_write_data), .mem_write_enable(mem_write_enable),
    .mem_read_enable(mem_read_enable), .alu_cnt(alu_cnt), .alu_result(alu_result),
    .iszero(iszero), .mem_read_data(mem_read_data)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int m_cnt(input logic [1:0] op, input logic [3:0] opc);
    if (op == 2'b01) return 1;
    if (op != 2'b00) return 0;
    if (opc >= 2 && opc <= 9) return int'(opc) - 2;
    return 0;
  endfunction

  function automatic logic [15:0] m_res(input int f, input logic [15:0] x, input logic [15:0] y);
    int unsigned ux = x, uy = y;
    case (f)
      0: return 16'((ux + uy) % 65536);
      1: return 16'((ux + 65536 - uy) % 65536);
      2: return 16'(65535 - ux);
      3: return (uy >= 16) ? 16'h0 : 16'((ux * (32'd1 << uy)) % 65536);
      4: return (uy >= 16) ? 16'h0 : 16'(ux / (32'd1 << uy));
      5: return x & y;
      6: return x | y;
      default: return (ux < uy) ? 16'd1 : 16'd0;
    endcase
  endfunction

  function automatic int m_idx(input logic [15:0] r);
    return (int'(r) % 16) / 2;
  endfunction

  task automatic drive(input logic [1:0] op, input logic [3:0] opc, input logic [15:0] x,
                       input logic [15:0] y, input logic we, input logic [15:0] wd, input logic re);
    alu_op = op; opcode = opc; a = x; b = y;
    mem_write_enable = we; mem_write_data = wd; mem_read_enable = re;
  endtask

  task automatic check_model(input string tag);
    int f;
    logic [15:0] r;
    f = m_cnt(alu_op, opcode);
    r = m_res(f, a, b);
    check({tag, ".cnt"}, {13'd0, alu_cnt}, 16'(f));
    check({tag, ".res"}, alu_result, r);
    check({tag, ".zero"}, {15'd0, iszero}, {15'd0, r == 16'h0});
    check({tag, ".rd"}, mem_read_data, mem_read_enable ? mem_m[m_idx(r)] : 16'h0);
  endtask

  task automatic model_edge();
    if (!reset && mem_write_enable) mem_m[m_idx(m_res(m_cnt(alu_op, opcode), a, b))] = mem_write_data;
  endtask

  initial begin
    logic [15:0] sweep [8];
    sweep = '{16'h00F4, 16'h00EC, 16'hFF0F, 16'h0F00, 16'h000F, 16'h0000, 16'h00F4, 16'h0000};
    foreach (mem_m[i]) mem_m[i] = '0;

    reset = 1'b1;
    drive(2'b00, 4'd2, 16'd3, 16'd4, 1'b0, 16'h0, 1'b1);
    #1;
    check("rst.rd", mem_read_data, 16'h0);
    check("rst.res", alu_result, 16'd7);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      drive(2'b00, 4'(i + 2), 16'h00F0, 16'h0004, 1'b0, 16'h0, 1'b0);
      #1;
      check($sformatf("sweep%0d.cnt", i), {13'd0, alu_cnt}, 16'(i));
      check($sformatf("sweep%0d.res", i), alu_result, sweep[i]);
      check($sformatf("sweep%0d.zero", i), {15'd0, iszero}, {15'd0, (i == 5 || i == 7)});
    end

    drive(2'b10, 4'b0111, 16'd5, 16'd3, 1'b0, 16'h0, 1'b0); #1;
    check("ovr10.cnt", {13'd0, alu_cnt}, 16'd0);
    check("ovr10.res", alu_result, 16'd8);
    drive(2'b01, 4'b0000, 16'h1234, 16'h1234, 1'b0, 16'h0, 1'b0); #1;
    check("ovr01.res", alu_result, 16'h0);
    check("ovr01.zero", {15'd0, iszero}, 16'd1);
    drive(2'b00, 4'd2, 16'hFFFF, 16'h0001, 1'b0, 16'h0, 1'b0); #1;
    check("addwrap.res", alu_result, 16'h0);
    check("addwrap.zero", {15'd0, iszero}, 16'd1);
    drive(2'b00, 4'd3, 16'h0000, 16'h0001, 1'b0, 16'h0, 1'b0); #1;
    check("subwrap.res", alu_result, 16'hFFFF);
    drive(2'b00, 4'd9, 16'h8000, 16'h0001, 1'b0, 16'h0, 1'b0); #1;
    check("sltuns.res", alu_result, 16'h0);
    drive(2'b00, 4'd5, 16'h00F0, 16'd16, 1'b0, 16'h0, 1'b0); #1;
    check("sll16.res", alu_result, 16'h0);

    @(negedge clk);
    drive(2'b10, 4'd0, 16'd0, 16'd6, 1'b1, 16'hBEEF, 1'b0);
    @(posedge clk); model_edge();
    @(negedge clk);
    drive(2'b10, 4'd0, 16'd0, 16'd6, 1'b0, 16'h0, 1'b1); #1;
    check("load6", mem_read_data, 16'hBEEF);
    b = 16'h0016; #1;
    check("load22", mem_read_data, 16'hBEEF);
    mem_read_enable = 1'b0; #1;
    check("loadoff", mem_read_data, 16'h0);

    @(negedge clk);
    drive(2'b10, 4'd0, 16'd0, 16'd6, 1'b1, 16'h1234, 1'b1); #1;
    check("rdw.pre", mem_read_data, 16'hBEEF);
    @(posedge clk); model_edge(); #1;
    check("rdw.post", mem_read_data, 16'h1234);

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(2'b10, 4'd0, 16'd0, 16'(2 * i), 1'b1, 16'(16'hA000 + i + 1), 1'b0);
      @(posedge clk); model_edge();
    end
    @(negedge clk);
    drive(2'b10, 4'd0, 16'd0, 16'd14, 1'b0, 16'h0, 1'b1); #1;
    check("fill7", mem_read_data, 16'hA008);
    reset = 1'b1; #1;
    reset = 1'b0;
    foreach (mem_m[i]) mem_m[i] = '0;
    for (int i = 0; i < 8; i++) begin
      b = 16'(2 * i); #0.5;
      check($sformatf("arst.w%0d", i), mem_read_data, 16'h0);
    end

    @(negedge clk);
    drive(2'b10, 4'd0, 16'd0, 16'd4, 1'b0, 16'h1111, 1'b0);
    @(posedge clk); model_edge();
    @(negedge clk);
    reset = 1'b1;
    drive(2'b10, 4'd0, 16'd0, 16'd4, 1'b1, 16'hABCD, 1'b1);
    @(posedge clk); model_edge(); #1;
    reset = 1'b0;
    mem_write_enable = 1'b0; #1;
    check("rstwr", mem_read_data, 16'h0);

    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      drive(2'($urandom_range(0, 3)), 4'($urandom), 16'($urandom),
            ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom),
            ($urandom_range(0, 2) == 0), 16'($urandom), $urandom_range(0, 1) == 1);
      #1;
      check_model($sformatf("rnd%0d", n));
      @(posedge clk); model_edge();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
